counter_ctrl: RTL and testbench

Synchronous sequencer for a WIDTH-bit up/down counter, the single-clock counterpart of the ripple counters in the counters library. It accepts start/stop/pause commands, preloads a start value, steps the count on each tick and flags terminal count. One-shot or auto-reload behaviour is selected at start time. The block drives timer/event logic that needs a deterministic, fully synchronous count.

---
 rtl/counter_ctrl.sv | 155 +++++++++++++++
 tb/tb_counter_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Synchronous start/stop/pause sequencer for a WIDTH-bit up/down counter with terminal-count flag.
// Optional prescaler enabled by defining COUNTER_CTRL_PRESCALE_EN (adds PS_WIDTH and ps_div).
module counter_ctrl #(
   parameter int unsigned WIDTH = 4
`ifdef COUNTER_CTRL_PRESCALE_EN
   ,
   parameter int unsigned PS_WIDTH = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mode,
   input  logic             dir,
`ifdef COUNTER_CTRL_PRESCALE_EN
   input  logic [PS_WIDTH-1:0] ps_div,
`endif
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state, state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic [WIDTH-1:0] cap_load, cap_load_nxt;
   logic             cap_mode, cap_mode_nxt;
   logic             cap_dir, cap_dir_nxt;
   logic [WIDTH-1:0] term;
   logic             at_term;
   logic             tick;

`ifdef COUNTER_CTRL_PRESCALE_EN
   logic [PS_WIDTH-1:0] ps_cnt, ps_cnt_nxt;
`endif

   // Terminal value follows the captured direction: all-ones counting up, zero counting down.
   assign term    = {WIDTH{~cap_dir}};
   assign at_term = (count == term);
   assign tc      = busy && at_term;

`ifdef COUNTER_CTRL_PRESCALE_EN
   assign tick = (ps_cnt == ps_div);
`else
   assign tick = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cap_load <= '0;
         cap_mode <= 1'b0;
         cap_dir  <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
         ps_cnt   <= '0;
`endif
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         cap_load <= cap_load_nxt;
         cap_mode <= cap_mode_nxt;
         cap_dir  <= cap_dir_nxt;
`ifdef COUNTER_CTRL_PRESCALE_EN
         ps_cnt   <= ps_cnt_nxt;
`endif
      end
   end

   // Next-state and datapath update; stop outranks stepping, stepping outranks nothing in PAUSE.
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      done_nxt     = 1'b0;
      cap_load_nxt = cap_load;
      cap_mode_nxt = cap_mode;
      cap_dir_nxt  = cap_dir;
`ifdef COUNTER_CTRL_PRESCALE_EN
      ps_cnt_nxt   = ps_cnt;
`endif

      case (state)
         ST_IDLE: begin
            if (start && !stop) begin
               cap_load_nxt = load_val;
               cap_mode_nxt = mode;
               cap_dir_nxt  = dir;
               count_nxt    = load_val;
               state_nxt    = ST_RUN;
`ifdef COUNTER_CTRL_PRESCALE_EN
               ps_cnt_nxt   = '0;
`endif
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (pause) begin
               state_nxt = ST_PAUSE;
            end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
               ps_cnt_nxt = tick ? '0 : ps_cnt + PS_WIDTH'(1);
`endif
               if (tick) begin
                  if (at_term) begin
                     done_nxt = 1'b1;
                     if (cap_mode) begin
                        count_nxt = cap_load;
                     end else begin
                        state_nxt = ST_DONE;
                     end
                  end else if (cap_dir) begin
                     count_nxt = count - WIDTH'(1);
                  end else begin
                     count_nxt = count + WIDTH'(1);
                  end
               end
            end
         end
         ST_PAUSE: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (!pause) begin
               state_nxt = ST_RUN;
`ifdef COUNTER_CTRL_PRESCALE_EN
               ps_cnt_nxt = '0;
`endif
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      busy_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomised and directed bench for counter_ctrl (default build, no prescaler), checked against
// a cycle-level behavioural model of the sequencer rules.
module tb_counter_ctrl;

   localparam int unsigned W = 4;
   localparam int TERM_UP = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst, start, stop, pause, mode, dir;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic         busy, tc, done;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: phase 0 idle, 1 counting, 2 paused, 3 finished
   int m_phase, m_cnt, m_load, m_mode, m_dir, m_done;

   counter_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .load_val(load_val), .mode(mode), .dir(dir),
      .count(count), .busy(busy), .tc(tc), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   function automatic int m_term();
      return (m_dir != 0) ? 0 : TERM_UP;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_phase = 0; m_cnt = 0; m_done = 0;
         m_load = 0; m_mode = 0; m_dir = 0;
         return;
      end
      m_done = 0;
      if (m_phase == 0) begin
         if (start && !stop) begin
            m_load = int'(load_val); m_mode = int'(mode); m_dir = int'(dir);
            m_cnt = m_load; m_phase = 1;
         end
      end else if (stop || m_phase == 3) begin
         m_phase = 0;
      end else if (m_phase == 2) begin
         if (!pause) m_phase = 1;
      end else if (pause) begin
         m_phase = 2;
      end else if (m_cnt == m_term()) begin
         m_done = 1;
         if (m_mode != 0) m_cnt = m_load;
         else m_phase = 3;
      end else begin
         m_cnt = (m_cnt + ((m_dir != 0) ? -1 : 1)) & TERM_UP;
      end
   endtask

   task automatic check_all();
      int m_busy;
      m_busy = (m_phase == 1 || m_phase == 2) ? 1 : 0;
      check("count", int'(count), m_cnt);
      check("busy", int'(busy), m_busy);
      check("done", int'(done), m_done);
      check("tc", int'(tc), (m_busy != 0 && m_cnt == m_term()) ? 1 : 0);
   endtask

   // Drive one cycle of inputs, advance model with the edge, then compare away from the edge
   task automatic cyc(input logic r, input logic st, input logic sp, input logic pa,
                      input int lv, input logic md, input logic dr);
      @(negedge clk);
      rst = r; start = st; stop = sp; pause = pa;
      load_val = W'(lv); mode = md; dir = dr;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
      load_val = '0; mode = 1'b0; dir = 1'b0;
      m_phase = 0; m_cnt = 0; m_load = 0; m_mode = 0; m_dir = 0; m_done = 0;

      // Reset then idle
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      idle(10);
      check("rst_count", int'(count), 0);

      // One-shot up from 13
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 13, 1'b0, 1'b0);
      check("os_e0", int'(count), 13);
      idle(2);
      check("os_tc_e2", int'(tc), 1);
      idle(1);
      check("os_done_e3", int'(done), 1);
      check("os_busy_e3", int'(busy), 0);
      idle(1);
      check("os_done_e4", int'(done), 0);
      check("os_cnt_e4", int'(count), 15);
      idle(2);

      // Auto-reload down from 2, then stop
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1);
      idle(9);
      check("ar_busy", int'(busy), 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      idle(2);

      // Pause at 5 for 4 cycles, resume, stop at 9
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
      idle(2);
      check("pz_at5", int'(count), 5);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      check("pz_frozen", int'(count), 5);
      idle(2);
      check("pz_resumed", int'(count), 6);
      idle(3);
      check("pz_at9", int'(count), 9);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      check("stop_cnt", int'(count), 9);
      check("stop_busy", int'(busy), 0);
      idle(2);

      // Start+stop in IDLE, start during RUN, load equal to terminal
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 7, 1'b0, 1'b0);
      check("col_idle", int'(busy), 0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      check("col_run", int'(count), 5);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 15, 1'b0, 1'b0);
      idle(1);
      check("term_load_done", int'(done), 1);
      idle(2);

      // Random traffic including occasional mid-run reset
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 4) == 0),
             int'($urandom_range(0, TERM_UP)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
